// File: rtl/proc_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit: funct3 opcodes,
// FSM states and operand-signedness decode.
package proc_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_signed_a(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/proc_muldiv_core.sv
// Unsigned magnitude datapath: W-step shift-add multiply or restoring divide in one
// 2W-bit register; acc_nxt_o is the value the current step will load.
module proc_muldiv_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           step_i,
  input  logic           is_div_i,
  input  logic [W-1:0]   mag_a_i,
  input  logic [W-1:0]   mag_b_i,
  output logic [2*W-1:0] acc_nxt_o,
  output logic           last_o
);

  localparam int CW = $clog2(W);

  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient}.
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   opd_q;
  logic [CW-1:0]  cnt_q;
  logic           is_div_q;

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opd_q} : {(W+1){1'b0}});
    shifted = {acc_q[2*W-1:W], acc_q[W-1]};
    diff    = shifted - {1'b0, opd_q};
    if (is_div_q) begin
      acc_nxt_o = diff[W] ? {shifted[W-1:0], acc_q[W-2:0], 1'b0}
                          : {diff[W-1:0],    acc_q[W-2:0], 1'b1};
    end else begin
      acc_nxt_o = {sum, acc_q[W-1:1]};
    end
  end

  assign last_o = (cnt_q == CW'(W-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opd_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else if (start_i) begin
      acc_q    <= {{W{1'b0}}, (is_div_i ? mag_a_i : mag_b_i)};
      opd_q    <= is_div_i ? mag_b_i : mag_a_i;
      cnt_q    <= '0;
      is_div_q <= is_div_i;
    end else if (step_i) begin
      acc_q <= acc_nxt_o;
      cnt_q <= last_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/proc_muldiv.sv
// RV32M mul/div unit: result strobes BUS_WIDTH+1 cycles after the handshake; one op in
// flight, o_ready low from handshake through DONE so issue must stall; i_flush aborts.
module proc_muldiv
  import proc_muldiv_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int REG_DPTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [2:0]                  i_op,
  input  logic [BUS_WIDTH-1:0]        i_rega_data,
  input  logic [BUS_WIDTH-1:0]        i_regb_data,
  input  logic [$clog2(REG_DPTH)-1:0] i_rd_add,
  input  logic                        i_flush,
  output logic                        o_busy,
  output logic                        o_valid,
  output logic                        o_reg_we,
  output logic [$clog2(REG_DPTH)-1:0] o_regw_add,
  output logic [BUS_WIDTH-1:0]        o_reg_data
);

  localparam int W  = BUS_WIDTH;
  localparam int AW = $clog2(REG_DPTH);

  state_t         state_q;
  logic [2:0]     op_q;
  logic [AW-1:0]  rd_q;
  logic           sa_q, sb_q, divz_q;
  logic [W-1:0]   rs1_q;
  logic           valid_q;
  logic [AW-1:0]  regw_add_q;
  logic [W-1:0]   reg_data_q;

  logic           sa_d, sb_d;
  logic [W-1:0]   mag_a_d, mag_b_d;
  logic           start, step, last;
  logic [2*W-1:0] acc_nxt, prod_s;
  logic [W-1:0]   quo, rem, result_d;

  assign start = (state_q == ST_IDLE) && i_valid && !i_flush;
  assign step  = (state_q == ST_CALC) && !i_flush;

  always_comb begin
    sa_d    = op_signed_a(i_op) & i_rega_data[W-1];
    sb_d    = op_signed_b(i_op) & i_regb_data[W-1];
    mag_a_d = sa_d ? -i_rega_data : i_rega_data;
    mag_b_d = sb_d ? -i_regb_data : i_regb_data;
  end

  proc_muldiv_core #(.W(W)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .step_i    (step),
    .is_div_i  (i_op[2]),
    .mag_a_i   (mag_a_d),
    .mag_b_i   (mag_b_d),
    .acc_nxt_o (acc_nxt),
    .last_o    (last)
  );

  // MIN/-1 needs no special path: |MIN|/1 = 2^(W-1), whose negation is MIN again, rem 0.
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
    quo    = acc_nxt[W-1:0];
    rem    = acc_nxt[2*W-1:W];
    case (op_q)
      OP_MUL:                      result_d = prod_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_s[2*W-1:W];
      OP_DIV, OP_DIVU:             result_d = divz_q ? {W{1'b1}} : ((sa_q ^ sb_q) ? -quo : quo);
      default:                     result_d = divz_q ? rs1_q : (sa_q ? -rem : rem);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      divz_q     <= 1'b0;
      rs1_q      <= '0;
      valid_q    <= 1'b0;
      regw_add_q <= '0;
      reg_data_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= i_op;
            rd_q    <= i_rd_add;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            divz_q  <= (i_regb_data == '0);
            rs1_q   <= i_rega_data;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (i_flush) begin
            state_q <= ST_IDLE;
          end else if (last) begin
            reg_data_q <= result_d;
            regw_add_q <= rd_q;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_valid    = valid_q;
  assign o_reg_we   = valid_q && (regw_add_q != '0);
  assign o_regw_add = regw_add_q;
  assign o_reg_data = reg_data_q;

endmodule

// File: tb/tb_proc_muldiv.sv
// Scoreboard bench for proc_muldiv: directed vectors, random ops against a 64-bit
// arithmetic model, flush/reset aborts and back-to-back issue.
module tb_proc_muldiv;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_flush = 1'b0;
  logic [2:0]    i_op = '0;
  logic [W-1:0]  i_rega_data = '0;
  logic [W-1:0]  i_regb_data = '0;
  logic [AW-1:0] i_rd_add = '0;
  logic          o_ready, o_busy, o_valid, o_reg_we;
  logic [AW-1:0] o_regw_add;
  logic [W-1:0]  o_reg_data;

  proc_muldiv #(.BUS_WIDTH(W), .REG_DPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_rega_data(i_rega_data), .i_regb_data(i_regb_data), .i_rd_add(i_rd_add),
    .i_flush(i_flush), .o_busy(o_busy), .o_valid(o_valid), .o_reg_we(o_reg_we),
    .o_regw_add(o_regw_add), .o_reg_data(o_reg_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] rd; logic [W-1:0] data; } exp_t;
  typedef struct { logic [2:0] op; logic [W-1:0] x; logic [W-1:0] y; logic [AW-1:0] rd; logic [W-1:0] exp; } vec_t;
  typedef struct { int lat; bit got; logic [AW-1:0] add; logic [W-1:0] dat; logic we; bit busy; bit after_ok; } obs_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int vld_seen = 0;

  always @(posedge clk) if (o_valid === 1'b1) vld_seen++;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    longint unsigned ux, uy, up;
    logic [63:0] r64;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      3'd0: begin up = ux * uy; r64 = up; return r64[31:0]; end
      3'd1: begin p = sx * sy; r64 = p; return r64[63:32]; end
      3'd2: begin p = sx * longint'(uy); r64 = p; return r64[63:32]; end
      3'd3: begin up = ux * uy; r64 = up; return r64[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sx / sy);
      end
      3'd5: return (y == 0) ? 32'hFFFFFFFF : 32'(ux / uy);
      3'd6: return (y == 0) ? x : 32'(sx % sy);
      default: return (y == 0) ? x : 32'(ux % uy);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [AW-1:0] r, input logic [W-1:0] exp_d, input bit push);
    exp_t e;
    i_valid = 1'b1; i_op = op; i_rega_data = x; i_regb_data = y; i_rd_add = r;
    if (push) begin e.rd = r; e.data = exp_d; sb.push_back(e); end
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_op = 3'($urandom); i_rega_data = $urandom; i_regb_data = $urandom; i_rd_add = AW'($urandom);
  endtask

  task automatic collect(output obs_t o, output exp_t e);
    o.lat = 1;
    while (o_valid !== 1'b1 && o.lat < 100) begin @(negedge clk); o.lat++; end
    o.got  = (o_valid === 1'b1);
    o.add  = o_regw_add;
    o.dat  = o_reg_data;
    o.we   = o_reg_we;
    o.busy = (o_busy === 1'b1 && o_ready === 1'b0);
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.rd = '0; e.data = 'x; end
    @(negedge clk);
    o.after_ok = (o_valid === 1'b0 && o_reg_we === 1'b0 && o_ready === 1'b1 && o_busy === 1'b0 &&
                  o_reg_data === o.dat && o_regw_add === o.add);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_reg_we !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ctrl: valid=%b we=%b busy=%b ready=%b want 0 0 0 1", o_valid, o_reg_we, o_busy, o_ready);
    end
    checks++;
    if (o_regw_add !== '0 || o_reg_data !== '0) begin
      errors++; $display("FAIL reset_wb: add=%0d data=%h want 0 0", o_regw_add, o_reg_data);
    end
  endtask

  task automatic test_mul();
    vec_t t[$]; obs_t o; exp_t e; logic [2:0] op; logic [W-1:0] x, y;
    t.push_back('{3'd0, 32'd7,         32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB});
    t.push_back('{3'd1, 32'h80000000,  32'h80000000, 5'd1, 32'h40000000});
    t.push_back('{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE});
    t.push_back('{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF});
    for (int i = 0; i < 4; i++) begin
      op = 3'($urandom_range(0, 3)); x = $urandom; y = $urandom;
      t.push_back('{op, x, y, AW'(i + 10), ref_model(op, x, y)});
    end
    foreach (t[i]) begin
      issue(t[i].op, t[i].x, t[i].y, t[i].rd, t[i].exp, 1'b1);
      collect(o, e);
      checks++; if (!o.got || o.lat != W + 1) begin errors++; $display("FAIL mul_latency[%0d]: got=%0d lat=%0d want %0d", i, o.got, o.lat, W + 1); end
      checks++; if (o.dat !== e.data) begin errors++; $display("FAIL mul_data[%0d]: op=%0d data=%h want %h", i, t[i].op, o.dat, e.data); end
      checks++; if (o.add !== e.rd || o.we !== (e.rd != '0)) begin errors++; $display("FAIL mul_wb[%0d]: add=%0d we=%b want add=%0d", i, o.add, o.we, e.rd); end
      checks++; if (!o.busy || !o.after_ok) begin errors++; $display("FAIL mul_pulse[%0d]: busy_in_done=%b clean_after=%b want 1 1", i, o.busy, o.after_ok); end
    end
  endtask

  task automatic test_div();
    vec_t t[$]; obs_t o; exp_t e; logic [2:0] op; logic [W-1:0] x, y;
    t.push_back('{3'd4, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD});
    t.push_back('{3'd6, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF});
    t.push_back('{3'd5, 32'd100,      32'd7, 5'd8, 32'd14});
    t.push_back('{3'd7, 32'd100,      32'd7, 5'd9, 32'd2});
    for (int i = 0; i < 4; i++) begin
      op = 3'($urandom_range(4, 7)); x = $urandom;
      y = (i == 3) ? 32'd0 : ((i == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      t.push_back('{op, x, y, AW'(i + 20), ref_model(op, x, y)});
    end
    foreach (t[i]) begin
      issue(t[i].op, t[i].x, t[i].y, t[i].rd, t[i].exp, 1'b1);
      collect(o, e);
      checks++; if (!o.got || o.lat != W + 1) begin errors++; $display("FAIL div_latency[%0d]: got=%0d lat=%0d want %0d", i, o.got, o.lat, W + 1); end
      checks++; if (o.dat !== e.data) begin errors++; $display("FAIL div_data[%0d]: op=%0d data=%h want %h", i, t[i].op, o.dat, e.data); end
      checks++; if (o.add !== e.rd || o.we !== (e.rd != '0)) begin errors++; $display("FAIL div_wb[%0d]: add=%0d we=%b want add=%0d", i, o.add, o.we, e.rd); end
      checks++; if (!o.busy || !o.after_ok) begin errors++; $display("FAIL div_pulse[%0d]: busy_in_done=%b clean_after=%b want 1 1", i, o.busy, o.after_ok); end
    end
  endtask

  task automatic test_div_special();
    vec_t t[$]; obs_t o; exp_t e;
    t.push_back('{3'd4, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF});
    t.push_back('{3'd6, 32'd5,        32'd0,        5'd12, 32'd5});
    t.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000});
    t.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0});
    t.push_back('{3'd4, 32'hFFFFFFFB, 32'd0,        5'd15, 32'hFFFFFFFF});
    t.push_back('{3'd6, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFB});
    t.push_back('{3'd5, 32'h00001234, 32'd0,        5'd17, 32'hFFFFFFFF});
    t.push_back('{3'd7, 32'h00001234, 32'd0,        5'd18, 32'h00001234});
    foreach (t[i]) begin
      issue(t[i].op, t[i].x, t[i].y, t[i].rd, t[i].exp, 1'b1);
      collect(o, e);
      checks++; if (!o.got || o.lat != W + 1) begin errors++; $display("FAIL special_latency[%0d]: got=%0d lat=%0d want %0d", i, o.got, o.lat, W + 1); end
      checks++; if (o.dat !== e.data) begin errors++; $display("FAIL special_data[%0d]: op=%0d data=%h want %h", i, t[i].op, o.dat, e.data); end
      checks++; if (o.add !== e.rd || o.we !== 1'b1) begin errors++; $display("FAIL special_wb[%0d]: add=%0d we=%b want add=%0d we=1", i, o.add, o.we, e.rd); end
    end
  endtask

  task automatic test_flush();
    obs_t o; exp_t e; int v0;
    v0 = vld_seen;
    // Flush wins over a simultaneous request in IDLE.
    i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd0; i_rega_data = 32'd2; i_regb_data = 32'd2; i_rd_add = 5'd3;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: busy=%b ready=%b want 0 1", o_busy, o_ready); end
    // Abort in CALC.
    issue(3'd0, 32'h1234, 32'h5678, 5'd9, '0, 1'b0);
    repeat (9) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL flush_calc: busy=%b ready=%b valid=%b want 0 1 0", o_busy, o_ready, o_valid); end
    issue(3'd0, 32'd3, 32'd4, 5'd6, 32'd12, 1'b1);
    collect(o, e);
    checks++; if (!o.got || o.lat != W + 1 || o.dat !== e.data || o.add !== e.rd) begin
      errors++; $display("FAIL flush_next_op: got=%0d lat=%0d data=%h add=%0d want lat=%0d data=%h add=%0d", o.got, o.lat, o.dat, o.add, W + 1, e.data, e.rd);
    end
    checks++; if (vld_seen != v0 + 1) begin errors++; $display("FAIL flush_count: valid pulses=%0d want %0d", vld_seen - v0, 1); end
    // Flush in DONE does not suppress the committed write.
    issue(3'd0, 32'd9, 32'd9, 5'd4, '0, 1'b0);
    repeat (32) @(negedge clk);
    i_flush = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b1 || o_reg_we !== 1'b1 || o_reg_data !== 32'd81 || o_regw_add !== 5'd4) begin
      errors++; $display("FAIL flush_done: valid=%b we=%b data=%h add=%0d want 1 1 00000051 4", o_valid, o_reg_we, o_reg_data, o_regw_add);
    end
    @(negedge clk);
    i_flush = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_reg_data !== 32'd81) begin errors++; $display("FAIL flush_done_after: busy=%b valid=%b data=%h want 0 0 00000051", o_busy, o_valid, o_reg_data); end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e; int v0;
    v0 = vld_seen;
    issue(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd8, '0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0 || o_reg_data !== '0 || o_regw_add !== '0) begin
      errors++; $display("FAIL reset_mid: busy=%b ready=%b valid=%b data=%h add=%0d want 0 1 0 0 0", o_busy, o_ready, o_valid, o_reg_data, o_regw_add);
    end
    issue(3'd0, 32'd3, 32'd4, 5'd6, 32'd12, 1'b1);
    collect(o, e);
    checks++; if (!o.got || o.lat != W + 1 || o.dat !== e.data || o.add !== e.rd) begin
      errors++; $display("FAIL reset_next_op: got=%0d lat=%0d data=%h add=%0d want lat=%0d data=%h add=%0d", o.got, o.lat, o.dat, o.add, W + 1, e.data, e.rd);
    end
    checks++; if (vld_seen != v0 + 1) begin errors++; $display("FAIL reset_count: valid pulses=%0d want %0d", vld_seen - v0, 1); end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e, nb; int v0;
    v0 = vld_seen;
    i_valid = 1'b1; i_op = 3'd0; i_rega_data = 32'd3; i_regb_data = 32'd4; i_rd_add = 5'd0;
    e.rd = 5'd0; e.data = 32'd12; sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Second request held high throughout; operands change after the first handshake.
    i_rega_data = 32'd5; i_regb_data = 32'd6; i_rd_add = 5'd7;
    collect(o, e);
    checks++; if (!o.got || o.lat != W + 1 || o.dat !== 32'd12) begin errors++; $display("FAIL b2b_first: got=%0d lat=%0d data=%h want lat=%0d data=0000000c", o.got, o.lat, o.dat, W + 1); end
    checks++; if (o.add !== 5'd0 || o.we !== 1'b0 || !o.busy) begin errors++; $display("FAIL b2b_x0: add=%0d we=%b busy_in_done=%b want 0 0 1", o.add, o.we, o.busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: ready=%b want 1 after DONE", o_ready); end
    nb.rd = 5'd7; nb.data = 32'd30; sb.push_back(nb);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    collect(o, e);
    checks++; if (!o.got || o.lat != W + 1 || o.dat !== e.data || o.add !== e.rd || o.we !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got=%0d lat=%0d data=%h add=%0d we=%b want lat=%0d data=%h add=%0d we=1", o.got, o.lat, o.dat, o.add, o.we, W + 1, e.data, e.rd);
    end
    checks++; if (vld_seen != v0 + 2) begin errors++; $display("FAIL b2b_count: valid pulses=%0d want %0d", vld_seen - v0, 2); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
